// File: rtl/fan_speed_decoder.sv
// PWM fan tachometer: measures high width and period of pwm_in and reports
// duty (0..255) per legal frame, flags illegal frames and a stalled line.
module fan_speed_decoder #(
  parameter int unsigned FRAME   = 257,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       pwm_in,
  output logic [7:0] speed,
  output logic       speed_valid,
  output logic       period_err,
  output logic       stuck
);

  localparam int unsigned IW      = $clog2(TIMEOUT + 1);
  localparam logic [9:0]  CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state;
  logic          sync1, sync2, sync_d;
  logic          rise, fall;
  logic          timeout_hit, frame_ok;
  logic [9:0]    per_cnt, hi_cnt, h_lat;
  logic [IW-1:0] idle_cnt;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;

  // A coincident edge always beats the timeout; idle_cnt holds at TIMEOUT so it fires once.
  always_comb begin
    timeout_hit = !(rise || fall) && (idle_cnt == IW'(TIMEOUT - 1));
    frame_ok    = (per_cnt == 10'(FRAME)) && (h_lat != '0) && (h_lat <= 10'd256);
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state       <= IDLE;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      h_lat       <= '0;
      idle_cnt    <= '0;
      speed       <= '0;
      speed_valid <= 1'b0;
      period_err  <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (per_cnt != CNT_MAX) per_cnt <= per_cnt + 10'd1;
      if (hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + 10'd1;

      if (rise || fall)
        idle_cnt <= '0;
      else if (idle_cnt != IW'(TIMEOUT))
        idle_cnt <= idle_cnt + 1'b1;

      // Counters restart at 1 on the rise so their value at a strobe equals the span in cycles.
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= HIGH;
            per_cnt <= 10'd1;
            hi_cnt  <= 10'd1;
            stuck   <= 1'b0;
          end
        end
        HIGH: begin
          if (fall) begin
            h_lat <= hi_cnt;
            state <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            if (frame_ok) begin
              speed       <= h_lat[7:0] - 8'd1;
              speed_valid <= 1'b1;
              period_err  <= 1'b0;
            end else begin
              period_err  <= 1'b1;
            end
            per_cnt <= 10'd1;
            hi_cnt  <= 10'd1;
            state   <= HIGH;
          end
        end
        default: state <= IDLE;
      endcase

      if (timeout_hit) begin
        stuck <= 1'b1;
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_fan_speed_decoder.sv
// Randomized bench for fan_speed_decoder: an event-time reference model feeds a
// scoreboard of expected speed_valid pulses; a negedge monitor checks pulses and levels.
module tb_fan_speed_decoder;

  localparam int unsigned FRAME   = 257;
  localparam int unsigned TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       arst = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] speed;
  logic       speed_valid, period_err, stuck;

  always #5 clk = ~clk;

  fan_speed_decoder #(.FRAME(FRAME), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .arst       (arst),
    .pwm_in     (pwm_in),
    .speed      (speed),
    .speed_valid(speed_valid),
    .period_err (period_err),
    .stuck      (stuck)
  );

  typedef struct { int t; int spd; } exp_t;
  typedef struct { bit lvl; int t; } edge_t;

  exp_t  sb_q[$];
  edge_t pend_q[$];
  int    tests = 0;
  int    fails = 0;
  int    pcount = 0;
  int    m_speed = 0;
  bit    m_err = 1'b0;
  bit    m_stuck = 1'b0;

  always @(posedge clk) pcount <= pcount + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, pcount);
    end
  endtask

  // Reference model: pwm transitions reach the decoder 2 posedges after first being sampled;
  // frame rules are applied to those event timestamps.
  initial begin : model
    bit    last_lvl, have_rise, have_fall, fresh, strobe, lvl;
    int    rise_t, fall_t, last_strobe, p, per, hi;
    edge_t e;
    last_lvl = 0; have_rise = 0; have_fall = 0; fresh = 1;
    rise_t = 0; fall_t = 0; last_strobe = 0;
    forever begin
      @(posedge clk or negedge arst);
      if (!arst) begin
        last_lvl = 0; have_rise = 0; have_fall = 0; fresh = 1;
        m_speed = 0; m_err = 0; m_stuck = 0;
        sb_q.delete();
        pend_q.delete();
      end else begin
        p = pcount + 1;
        if (fresh) begin
          last_strobe = p - 1;
          fresh = 0;
        end
        if (pwm_in !== last_lvl) begin
          pend_q.push_back('{pwm_in, p + 2});
          last_lvl = pwm_in;
        end
        strobe = 0;
        lvl = 0;
        if (pend_q.size() > 0 && pend_q[0].t == p) begin
          e = pend_q.pop_front();
          strobe = 1;
          lvl = e.lvl;
          last_strobe = p;
        end
        if (strobe && lvl) begin
          m_stuck = 0;
          if (have_rise && have_fall) begin
            per = (p - rise_t > 1023) ? 1023 : p - rise_t;
            hi  = (fall_t - rise_t > 1023) ? 1023 : fall_t - rise_t;
            if (per == int'(FRAME) && hi >= 1 && hi <= 256) begin
              m_speed = hi - 1;
              m_err = 0;
              sb_q.push_back('{p, hi - 1});
            end else begin
              m_err = 1;
            end
          end
          have_rise = 1;
          have_fall = 0;
          rise_t = p;
        end else if (strobe) begin
          if (have_rise && !have_fall) begin
            have_fall = 1;
            fall_t = p;
          end
        end else if (p - last_strobe == int'(TIMEOUT)) begin
          m_stuck = 1;
          have_rise = 0;
          have_fall = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (!arst) begin
        chk("rst_speed", int'(speed), 0);
        chk("rst_valid", int'(speed_valid), 0);
        chk("rst_err", int'(period_err), 0);
        chk("rst_stuck", int'(stuck), 0);
      end else begin
        if (speed_valid) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got pulse with speed %0d, expected no pulse (cycle %0d)",
                     speed, pcount);
          end else begin
            x = sb_q.pop_front();
            chk("valid_time", pcount, x.t);
            chk("valid_speed", int'(speed), x.spd);
          end
        end else if (sb_q.size() > 0 && sb_q[0].t <= pcount) begin
          x = sb_q.pop_front();
          tests++;
          fails++;
          $display("FAIL missed_valid: got no pulse, expected speed %0d at cycle %0d", x.spd, x.t);
        end
        chk("speed", int'(speed), m_speed);
        chk("period_err", int'(period_err), int'(m_err));
        chk("stuck", int'(stuck), int'(m_stuck));
      end
    end
  end

  task automatic hold(input bit lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input int h, input int per);
    hold(1'b1, h);
    hold(1'b0, per - h);
  endtask

  initial begin : stimulus
    int h, per;
    repeat (3) @(posedge clk);
    #1 arst = 1'b1;

    repeat (4) frame(101, 257);
    repeat (3) frame(1, 257);
    repeat (3) frame(256, 257);
    repeat (10) frame(int'($urandom_range(1, 256)), 257);

    repeat (2) frame(50, 300);
    repeat (3) frame(int'($urandom_range(1, 256)), 257);
    repeat (4) begin
      per = int'($urandom_range(200, 320));
      if (per == 257) per = 258;
      h = int'($urandom_range(1, per - 1));
      frame(h, per);
    end
    repeat (2) frame(int'($urandom_range(1, 256)), 257);

    hold(1'b1, 1100);
    hold(1'b0, 156);
    repeat (3) frame(int'($urandom_range(1, 256)), 257);

    hold(1'b1, 50);
    hold(1'b0, int'(TIMEOUT));
    repeat (2) frame(int'($urandom_range(1, 256)), 257);
    hold(1'b1, 50);
    hold(1'b0, int'(TIMEOUT) + 1);
    repeat (3) frame(int'($urandom_range(1, 256)), 257);

    repeat (2) frame(201, 257);
    hold(1'b1, 100);
    arst = 1'b0;
    #1;
    chk("async_rst_speed", int'(speed), 0);
    chk("async_rst_valid", int'(speed_valid), 0);
    chk("async_rst_err", int'(period_err), 0);
    chk("async_rst_stuck", int'(stuck), 0);
    hold(1'b1, 4);
    arst = 1'b1;
    hold(1'b1, 97);
    hold(1'b0, 56);
    repeat (3) frame(201, 257);

    hold(1'b0, 10);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected stimulus to complete");
    $fatal(1, "watchdog expired");
  end

endmodule
